uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter multiplexing requester byte bursts onto one UART transmitter
// Optional macro UART_ARB_ID_HEADER_EN prefixes each burst with an owner-id header byte {4'hA,1'b0,grant_id}.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_start,
    input  logic              uart_tx_ready,
    output logic [2:0]        grant_id,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, HDR} state_t;

    state_t          state_q;
    logic [2:0]      rr_ptr_q;
    logic [2:0]      grant_q;
    logic            busy_q;
    logic [NREQ-1:0] ready_q;
    logic            start_q;
    logic [7:0]      tx_data_q;
    logic [7:0]      byte_q;
    logic            last_q;
    logic [7:0]      count_q;
`ifdef UART_ARB_ID_HEADER_EN
    logic            hdr_q;
`endif

    // Requester vectors padded to 8 entries so a 3-bit owner index selects them directly.
    logic [7:0]  valid_pad;
    logic [7:0]  last_pad;
    logic [63:0] data_pad;
    assign valid_pad = 8'(req_valid);
    assign last_pad  = 8'(req_last);
    assign data_pad  = 64'(req_data);

    logic [2:0] arb_id_d;
    logic       arb_hit_d;
    logic [2:0] hi_id, lo_id;
    logic       hi_hit, lo_hit;
    logic       burst_done;

    // Round-robin: lowest valid index above rr_ptr wins, else wrap to the lowest valid index.
    always_comb begin
        hi_id  = '0;
        lo_id  = '0;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (3'(i) > rr_ptr_q) begin
                    hi_hit = 1'b1;
                    hi_id  = 3'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_id  = 3'(i);
                end
            end
        end
        arb_hit_d = hi_hit | lo_hit;
        arb_id_d  = hi_hit ? hi_id : lo_id;
    end

    assign burst_done = last_q || (count_q == 8'(LOCK_MAX)) || !valid_pad[grant_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 3'(NREQ - 1);
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ready_q   <= '0;
            start_q   <= 1'b0;
            tx_data_q <= '0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            count_q   <= '0;
`ifdef UART_ARB_ID_HEADER_EN
            hdr_q     <= 1'b0;
`endif
        end else begin
            ready_q <= '0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_hit_d) begin
                        grant_q <= arb_id_d;
                        busy_q  <= 1'b1;
`ifdef UART_ARB_ID_HEADER_EN
                        state_q <= HDR;
`else
                        ready_q <= NREQ'(8'd1 << arb_id_d);
                        state_q <= GRANT;
`endif
                    end
                end
`ifdef UART_ARB_ID_HEADER_EN
                HDR: begin
                    byte_q  <= {4'hA, 1'b0, grant_q};
                    hdr_q   <= 1'b1;
                    state_q <= SEND;
                end
`endif
                GRANT: begin
                    if (valid_pad[grant_q]) begin
                        byte_q  <= data_pad[{grant_q, 3'b000} +: 8];
                        last_q  <= last_pad[grant_q];
                        count_q <= count_q + 8'd1;
                        state_q <= SEND;
                    end else begin
                        rr_ptr_q <= grant_q;
                        count_q  <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                SEND: begin
                    if (uart_tx_ready) begin
                        tx_data_q <= byte_q;
                        start_q   <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // start_q is high only on the first WAIT cycle, when the UART has not yet dropped ready.
                    if (!start_q && uart_tx_ready) begin
`ifdef UART_ARB_ID_HEADER_EN
                        if (hdr_q) begin
                            hdr_q   <= 1'b0;
                            ready_q <= NREQ'(8'd1 << grant_q);
                            state_q <= GRANT;
                        end else
`endif
                        if (burst_done) begin
                            rr_ptr_q <= grant_q;
                            count_q  <= '0;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            ready_q <= NREQ'(8'd1 << grant_q);
                            state_q <= GRANT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = ready_q;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_start = start_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic              uart_tx_ready;

    logic [NREQ-1:0] req_ready, lk_req_ready;
    logic [7:0]      uart_tx_data, lk_uart_tx_data;
    logic            uart_tx_start, lk_uart_tx_start;
    logic [2:0]      grant_id, lk_grant_id;
    logic            busy, lk_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_MAX(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
        .uart_tx_ready(uart_tx_ready), .grant_id(grant_id), .busy(busy)
    );

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_MAX(2)) u_lock (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(lk_req_ready), .uart_tx_data(lk_uart_tx_data), .uart_tx_start(lk_uart_tx_start),
        .uart_tx_ready(uart_tx_ready), .grant_id(lk_grant_id), .busy(lk_busy)
    );

    logic            use_lock;
    logic [NREQ-1:0] s_ready;
    logic            s_start, s_busy;
    logic [7:0]      s_data;
    logic [2:0]      s_gid;
    assign s_ready = use_lock ? lk_req_ready     : req_ready;
    assign s_start = use_lock ? lk_uart_tx_start : uart_tx_start;
    assign s_data  = use_lock ? lk_uart_tx_data  : uart_tx_data;
    assign s_gid   = use_lock ? lk_grant_id      : grant_id;
    assign s_busy  = use_lock ? lk_busy          : busy;

    logic [8:0] src_mem [NREQ][16];
    int         src_len [NREQ];
    int         src_pos [NREQ];
    logic [7:0] got_data[$];
    logic [2:0] got_gid[$];
    int n_xfer, onehot_viol;
    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] last;
        logic [7:0]      d;
        logic            urdy;
        logic [NREQ-1:0] e_ready;
        logic            e_start;
        logic [7:0]      e_data;
        logic            e_busy;
        logic [2:0]      e_gid;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i]         = 1'b1;
                req_data[8*i +: 8]   = src_mem[i][src_pos[i]][7:0];
                req_last[i]          = src_mem[i][src_pos[i]][8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[8*i +: 8]   = 8'h00;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_len[r]] = {l, d};
        src_len[r]++;
    endtask

    // One clock: note handshakes before the edge, then advance sources and log start pulses after it.
    task automatic step();
        logic [NREQ-1:0] xfer;
        @(negedge clk);
        xfer = s_ready & req_valid;
        if (!$onehot0(s_ready)) onehot_viol++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer[i]) begin
                src_pos[i]++;
                n_xfer++;
            end
        end
        if (s_start) begin
            got_data.push_back(s_data);
            got_gid.push_back(s_gid);
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        drive_inputs();
        uart_tx_ready = 1'b1;
        got_data.delete();
        got_gid.delete();
        n_xfer = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_until(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (got_data.size() < n && c < budget) begin
            step();
            c++;
        end
        check(name, got_data.size(), n);
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (s_busy && c < 50) begin
            step();
            c++;
        end
        check(name, int'(s_busy), 0);
    endtask

    task automatic expect_seq(input string name, input int idx, input logic [2:0] gid, input logic [7:0] d);
        check({name, "_gid"}, int'(got_gid[idx]), int'(gid));
        check({name, "_data"}, int'(got_data[idx]), int'(d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        use_lock = 1'b0;
        onehot_viol = 0;
        do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", int'(req_ready), 0);
        check("rst_start", int'(uart_tx_start), 0);
        check("rst_data", int'(uart_tx_data), 0);
        check("rst_gid", int'(grant_id), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

`ifdef UART_ARB_ID_HEADER_EN
        do_reset();
        push(2, 8'h5A, 1'b1);
        drive_inputs();
        run_until("hdr_starts", 2, 100);
        expect_seq("hdr0", 0, 3'd2, 8'hA2);
        expect_seq("hdr1", 1, 3'd2, 8'h5A);
        wait_idle("hdr_idle");
        check("hdr_xfers", n_xfer, 1);
`else
        //           valid    last     d      urdy  e_ready  st    e_data  busy  gid
        tbl[0]  = '{4'b0001, 4'b0001, 8'h3C, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[1]  = '{4'b0001, 4'b0001, 8'h3C, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[2]  = '{4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[3]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 8'h3C, 1'b1, 3'd0};
        tbl[4]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h3C, 1'b1, 3'd0};
        tbl[5]  = '{4'b0100, 4'b0100, 8'h5D, 1'b1, 4'b0000, 1'b0, 8'h3C, 1'b0, 3'd0};
        tbl[6]  = '{4'b0100, 4'b0100, 8'h5D, 1'b1, 4'b0100, 1'b0, 8'h3C, 1'b1, 3'd2};
        tbl[7]  = '{4'b0100, 4'b0100, 8'h5D, 1'b1, 4'b0000, 1'b0, 8'h3C, 1'b1, 3'd2};
        tbl[8]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 8'h5D, 1'b1, 3'd2};
        tbl[9]  = '{4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h5D, 1'b1, 3'd2};
        tbl[10] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h5D, 1'b1, 3'd2};
        tbl[11] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h5D, 1'b0, 3'd2};
        tbl[12] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h5D, 1'b0, 3'd2};
        for (int r = 0; r < 13; r++) begin
            req_valid     = tbl[r].valid;
            req_last      = tbl[r].last;
            req_data      = {NREQ{tbl[r].d}};
            uart_tx_ready = tbl[r].urdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ready", r), int'(req_ready), int'(tbl[r].e_ready));
            check($sformatf("vec%0d_start", r), int'(uart_tx_start), int'(tbl[r].e_start));
            check($sformatf("vec%0d_data", r), int'(uart_tx_data), int'(tbl[r].e_data));
            check($sformatf("vec%0d_busy", r), int'(busy), int'(tbl[r].e_busy));
            check($sformatf("vec%0d_gid", r), int'(grant_id), int'(tbl[r].e_gid));
        end

        // Two single-byte requesters alternate.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push(0, 8'hA0 + 8'(k), 1'b1);
            push(2, 8'hC0 + 8'(k), 1'b1);
        end
        drive_inputs();
        run_until("alt_starts", 4, 200);
        expect_seq("alt0", 0, 3'd0, 8'hA0);
        expect_seq("alt1", 1, 3'd2, 8'hC0);
        expect_seq("alt2", 2, 3'd0, 8'hA1);
        expect_seq("alt3", 3, 3'd2, 8'hC1);
        for (int i = 0; i < NREQ; i++) src_pos[i] = src_len[i];
        drive_inputs();
        wait_idle("alt_idle");
        check("alt_start_per_byte", got_data.size(), n_xfer);

        // Multi-byte burst is not preempted.
        do_reset();
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        push(3, 8'h3F, 1'b1);
        drive_inputs();
        run_until("burst_starts", 4, 200);
        expect_seq("burst0", 0, 3'd1, 8'h11);
        expect_seq("burst1", 1, 3'd1, 8'h22);
        expect_seq("burst2", 2, 3'd1, 8'h33);
        expect_seq("burst3", 3, 3'd3, 8'h3F);
        wait_idle("burst_idle");

        // LOCK_MAX=2 forced release.
        use_lock = 1'b1;
        do_reset();
        for (int k = 1; k <= 5; k++) push(0, 8'(k), 1'b0);
        push(1, 8'h10, 1'b1);
        drive_inputs();
        run_until("lock_starts", 6, 300);
        expect_seq("lock0", 0, 3'd0, 8'h01);
        expect_seq("lock1", 1, 3'd0, 8'h02);
        expect_seq("lock2", 2, 3'd1, 8'h10);
        expect_seq("lock3", 3, 3'd0, 8'h03);
        expect_seq("lock4", 4, 3'd0, 8'h04);
        expect_seq("lock5", 5, 3'd0, 8'h05);
        wait_idle("lock_idle");
        use_lock = 1'b0;

        // UART busy for 50 cycles while in SEND.
        begin
            int bad;
            logic [7:0] held;
            do_reset();
            push(2, 8'h77, 1'b1);
            drive_inputs();
            uart_tx_ready = 1'b0;
            step();
            step();
            held = uart_tx_data;
            bad = 0;
            for (int c = 0; c < 50; c++) begin
                step();
                if (uart_tx_start || uart_tx_data != held || !busy) bad++;
            end
            check("stall_no_start", bad, 0);
            check("stall_data_held", int'(uart_tx_data), 0);
            uart_tx_ready = 1'b1;
            step();
            check("stall_release_start", int'(uart_tx_start), 1);
            check("stall_release_data", int'(uart_tx_data), 8'h77);
            check("stall_start_count", got_data.size(), 1);
            wait_idle("stall_idle");
        end

        // Reset in WAIT abandons the burst.
        do_reset();
        push(0, 8'h55, 1'b1);
        drive_inputs();
        step();
        step();
        step();
        check("rwait_start", int'(uart_tx_start), 1);
        uart_tx_ready = 1'b0;
        step();
        check("rwait_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("rwait_ready", int'(req_ready), 0);
        check("rwait_start0", int'(uart_tx_start), 0);
        check("rwait_data", int'(uart_tx_data), 0);
        check("rwait_gid", int'(grant_id), 0);
        check("rwait_busy0", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        uart_tx_ready = 1'b1;
        drive_inputs();
        got_data.delete();
        got_gid.delete();
        repeat (20) step();
        check("rwait_no_resend", got_data.size(), 0);
        check("rwait_idle", int'(busy), 0);
`endif

        check("ready_onehot", onehot_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
